// File: rtl/matmul_sequencer_if.sv
// Job interface of the 3x3 matrix-multiply sequencer: operands in, product
// and handshake status out. Matrices are packed row-major with [0][0] in
// the most significant W bits.
interface matmul_sequencer_if #(
  parameter int W = 16
);
  logic             start;
  logic [9*W-1:0]   A;
  logic [9*W-1:0]   B;
  logic [9*W-1:0]   Result;
  logic             busy;
  logic             done;

  // Requester side: issues jobs and observes status.
  modport master (
    output start, A, B,
    input  Result, busy, done
  );

  // Sequencer side: accepts jobs and reports the product.
  modport slave (
    input  start, A, B,
    output Result, busy, done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// 3x3 matrix-multiply sequencer. A job latches both operands, then performs
// one multiply-accumulate per cycle through a single shared W x W
// multiplier (27 cycles), and publishes the whole product matrix at once.
// All arithmetic wraps modulo 2^W.
module matmul_sequencer #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  matmul_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       i_q, i_d;
  logic [1:0]       j_q, j_d;
  logic [1:0]       k_q, k_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [9*W-1:0]   aop_q, aop_d;
  logic [9*W-1:0]   bop_q, bop_d;
  logic [9*W-1:0]   res_q, res_d;
  logic [W-1:0]     work_q [9];
  logic [W-1:0]     work_d [9];

  logic [3:0]       a_idx, b_idx;
  logic [W-1:0]     a_el, b_el;
  logic [W-1:0]     prod;
  logic [W-1:0]     sum;

  // Element e (= 3*row + col) of a packed row-major matrix.
  function automatic logic [W-1:0] elem(input logic [9*W-1:0] m,
                                        input logic [3:0]     e);
    return m[9*W-1 - W*int'(e) -: W];
  endfunction

  // Pack a working matrix back into the row-major bus format.
  function automatic logic [9*W-1:0] pack(input logic [W-1:0] w [9]);
    logic [9*W-1:0] p;
    p = '0;
    for (int e = 0; e < 9; e++) begin
      p[9*W-1 - W*e -: W] = w[e];
    end
    return p;
  endfunction

  // Shared multiplier: Aop[i][k] * Bop[k][j], truncated to W bits by the
  // W-bit destination, which is exactly the modulo-2^W product.
  assign a_idx = {2'b00, i_q} * 4'd3 + {2'b00, k_q};
  assign b_idx = {2'b00, k_q} * 4'd3 + {2'b00, j_q};
  assign a_el  = elem(aop_q, a_idx);
  assign b_el  = elem(bop_q, b_idx);
  assign prod  = a_el * b_el;
  assign sum   = acc_q + prod;

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    aop_d   = aop_q;
    bop_d   = bop_q;
    res_d   = res_q;
    work_d  = work_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          aop_d   = bus.A;
          bop_d   = bus.B;
          acc_d   = '0;
          i_d     = 2'd0;
          j_d     = 2'd0;
          k_d     = 2'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (k_q == 2'd2) begin
          // Last term of element [i][j]: retire it and restart the sum.
          work_d[a_idx - {2'b00, k_q} + {2'b00, j_q}] = sum;
          acc_d = '0;
          k_d   = 2'd0;
          if (j_q == 2'd2) begin
            j_d = 2'd0;
            if (i_q == 2'd2) begin
              i_d     = 2'd0;
              res_d   = pack(work_d);
              state_d = DONE;
            end else begin
              i_d = i_q + 2'd1;
            end
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register; reset wins over any pending start.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control and result registers, cleared by reset so an aborted job leaves
  // no trace on Result.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q   <= 2'd0;
      j_q   <= 2'd0;
      k_q   <= 2'd0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      i_q   <= i_d;
      j_q   <= j_d;
      k_q   <= k_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  // Operand copies and working matrix.
  // NOTE: these storage arrays are deliberately not reset: every job loads
  // the operands before use and writes all nine working elements before
  // they are published, so stale contents are never observable.
  always_ff @(posedge clk) begin
    aop_q  <= aop_d;
    bop_q  <= bop_d;
    work_q <= work_d;
  end

  assign bus.Result = res_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a reference model computes each
// expected product when a job is issued and queues it; a monitor pops and
// compares whenever done pulses.
module tb_matmul_sequencer;

  localparam int W  = 16;
  localparam int MW = 9 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matmul_sequencer_if #(.W(W)) bus ();

  matmul_sequencer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  int              done_count = 0;
  int              done_cyc [$];
  logic [MW-1:0]   sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [MW-1:0] got,
                       input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int e);
    return m[MW-1 - W*e -: W];
  endfunction

  // Reference product, modulo 2^W.
  function automatic logic [MW-1:0] matmul_ref(input logic [MW-1:0] a,
                                               input logic [MW-1:0] b);
    logic [MW-1:0] r;
    logic [W-1:0]  s;
    logic [W-1:0]  p;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = '0;
        for (int k = 0; k < 3; k++) begin
          p = el(a, 3*i + k) * el(b, 3*k + j);
          s = s + p;
        end
        r[MW-1 - W*(3*i + j) -: W] = s;
      end
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] mat(input int v0, v1, v2, v3, v4, v5,
                                        v6, v7, v8);
    return {16'(v0), 16'(v1), 16'(v2), 16'(v3), 16'(v4), 16'(v5),
            16'(v6), 16'(v7), 16'(v8)};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_count++;
      done_cyc.push_back(cyc);
      check("done_has_job", MW'(sb.size() > 0), MW'(1));
      if (sb.size() > 0) check("result", bus.Result, sb.pop_front());
    end
  end

  task automatic wait_done(input int target, input int budget,
                           input string tag);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, MW'(done_count >= target), MW'(1));
  endtask

  // One complete job with cycle-accurate busy/done checks. Starts and ends
  // at a falling edge with the DUT in IDLE.
  task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input string tag);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    sb.push_back(matmul_ref(a, b));
    @(negedge clk);
    bus.start = 1'b0;
    for (int m = 0; m < 27; m++) begin
      check({tag, "_busy_run"}, MW'(bus.busy), MW'(1));
      check({tag, "_done_run"}, MW'(bus.done), MW'(0));
      @(negedge clk);
    end
    check({tag, "_busy_done"}, MW'(bus.busy), MW'(0));
    check({tag, "_done_pulse"}, MW'(bus.done), MW'(1));
    @(negedge clk);
    check({tag, "_done_low"}, MW'(bus.done), MW'(0));
    check({tag, "_idle_busy"}, MW'(bus.busy), MW'(0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MW-1:0] ones;
    logic [MW-1:0] a0, b0, ra, rb;
    int            base;
    int            t_start;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    ones      = '1;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", MW'(bus.busy), MW'(0));
    check("rst_done", MW'(bus.done), MW'(0));
    check("rst_result", bus.Result, '0);
    @(negedge clk);

    // A = 1..9, B = identity.
    run_job(mat(1, 2, 3, 4, 5, 6, 7, 8, 9), mat(1, 0, 0, 0, 1, 0, 0, 0, 1),
            "ident");
    check("ident_hold", bus.Result, mat(1, 2, 3, 4, 5, 6, 7, 8, 9));

    // All-ones operands exercise modulo-2^W wrap: every element is 3.
    run_job(ones, ones, "wrap");
    check("wrap_value", bus.Result, mat(3, 3, 3, 3, 3, 3, 3, 3, 3));

    // Random operands.
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 9; e++) begin
        ra[MW-1 - W*e -: W] = W'($urandom);
        rb[MW-1 - W*e -: W] = W'($urandom);
      end
      run_job(ra, rb, "rand");
    end

    // Operands changed and start re-pulsed mid-job: one done, old operands.
    a0 = mat(2, 0, 1, 3, 5, 7, 1, 1, 1);
    b0 = mat(4, 1, 0, 2, 2, 2, 9, 8, 7);
    base = done_count;
    bus.A = a0;
    bus.B = b0;
    bus.start = 1'b1;
    sb.push_back(matmul_ref(a0, b0));
    @(negedge clk);
    t_start = cyc;
    bus.start = 1'b0;
    bus.A = mat(9, 9, 9, 9, 9, 9, 9, 9, 9);
    bus.B = mat(5, 4, 3, 2, 1, 0, 1, 2, 3);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(base + 1, 40, "ignore_done_seen");
    if (done_count > base)
      check("ignore_latency", MW'(done_cyc[base] - t_start), MW'(27));
    repeat (35) @(negedge clk);
    #1;
    check("ignore_one_done", MW'(done_count - base), MW'(1));

    // Reset mid-job at edge N+10, with start also high: no done follows.
    base = done_count;
    bus.A = mat(1, 1, 1, 1, 1, 1, 1, 1, 1);
    bus.B = mat(1, 1, 1, 1, 1, 1, 1, 1, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("abort_busy", MW'(bus.busy), MW'(0));
    check("abort_done", MW'(bus.done), MW'(0));
    check("abort_result", bus.Result, '0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_done", MW'(done_count - base), MW'(0));
    check("abort_result_hold", bus.Result, '0);

    // First start after reset runs normally.
    @(negedge clk);
    run_job(mat(1, 2, 3, 4, 5, 6, 7, 8, 9), mat(9, 8, 7, 6, 5, 4, 3, 2, 1),
            "post_rst");

    // start held high: three jobs, done every 29 cycles, identical results.
    base = done_count;
    bus.A = mat(3, 1, 4, 1, 5, 9, 2, 6, 5);
    bus.B = mat(2, 7, 1, 8, 2, 8, 1, 8, 2);
    for (int r = 0; r < 3; r++) sb.push_back(matmul_ref(bus.A, bus.B));
    bus.start = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      #1;
      if (done_count >= base + 2 && bus.busy) break;
    end
    bus.start = 1'b0;
    wait_done(base + 3, 40, "b2b_three_done");
    if (done_count >= base + 3) begin
      check("b2b_gap1", MW'(done_cyc[base+1] - done_cyc[base]), MW'(29));
      check("b2b_gap2", MW'(done_cyc[base+2] - done_cyc[base+1]), MW'(29));
    end
    repeat (35) @(negedge clk);
    #1;
    check("b2b_no_extra", MW'(done_count - base), MW'(3));
    check("sb_drained", MW'(sb.size()), MW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning element width in bits; the matrix dimension SHALL be fixed at 3x3.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, job request, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, 9*W (144), left operand, row-major; element [i][j] occupies bits 143-48i-16j down to 128-48i-16j, so [0][0] sits in the MSBs.
REQ-006 The block SHALL have port B, input, 9*W (144), right operand, packed as A.
REQ-007 The block SHALL have port Result, output, 9*W (144), registered product A x B, packed as A.
REQ-008 The block SHALL have port busy, output, 1, high while a job is in progress (state RUN).
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse when Result is updated.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at edge N, the block SHALL latch A and B into internal operand registers, clear the accumulator, set i=j=k=0, and enter RUN.
REQ-012 Operand changes on A/B after edge N SHALL NOT affect the running job.
REQ-013 In RUN, each cycle SHALL perform exactly one MAC, acc = acc + Aop[i][k]*Bop[k][j], using one shared W x W multiplier.
REQ-014 Indices SHALL advance k fastest, then j, then i, each wrapping 2->0; the sequence SHALL run 27 MAC cycles (edges N+1..N+27).
REQ-015 At the edge where k=2, the block SHALL write the final sum into working element [i][j] and clear the accumulator for the next element.
REQ-016 All arithmetic SHALL be modulo 2^W: products and sums truncated to W bits, matching a W-bit accumulator.
REQ-017 At edge N+27, the block SHALL copy the full working matrix (including [2][2]) to Result, enter DONE, assert done, and deassert busy.
REQ-018 Result SHALL change only at a completion edge or on reset; it SHALL hold between jobs.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE; done SHALL be high only in DONE.
REQ-020 start SHALL be ignored in RUN and in DONE; no job is queued.
REQ-021 With start held high continuously, a new job SHALL be accepted every 29 cycles: 1 IDLE + 27 RUN + 1 DONE.
REQ-022 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.

Reset
REQ-023 rst=1 at any edge, including mid-RUN and in DONE, SHALL force state IDLE, busy=0, done=0, Result=0, clear the accumulator, and clear i=j=k=0; the aborted job SHALL produce no done pulse.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 After rst falls, the first start sampled in IDLE SHALL begin a job normally.

Verification
REQ-026 A=[1..9] row-major, B=identity, start pulse at edge N -> busy high edges N+1..N+27, done high only in the cycle after edge N+27, and Result=[1,2,3,4,5,6,7,8,9].
REQ-027 A and B with all elements 0xFFFF -> every Result element = 0x0003 (each product 0xFFFE0001 truncates to 0x0001, times 3), confirming modulo-2^16 behaviour.
REQ-028 start pulsed at edge N+5 during a job and A/B changed after edge N -> exactly one done, at edge N+27, and Result reflects the operands latched at edge N.
REQ-029 rst asserted at edge N+10 of a job -> busy=0, done=0, Result=0 from the next cycle, and no done pulse follows.
REQ-030 start held high for 3 jobs with fixed operands -> done pulses spaced exactly 29 cycles apart, and Result is identical for each job.
